// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU and its downstream result queue:
//   - opcode encodings driven into the ALU
//   - alu_entry_t : one queued ALU result with its flags, opcode and tag
//   - carry_valid : whether an opcode produces a meaningful carry flag
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int ALU_WIDTH = 128;
    localparam int ALU_TAG_W = 5;

    localparam logic [3:0] XOR   = 4'd0;
    localparam logic [3:0] ADD   = 4'd1;
    localparam logic [3:0] SLT   = 4'd2;
    localparam logic [3:0] SGE   = 4'd3;
    localparam logic [3:0] PASSB = 4'd4;
    localparam logic [3:0] SRL   = 4'd5;
    localparam logic [3:0] SUB   = 4'd6;
    localparam logic [3:0] OR    = 4'd7;
    localparam logic [3:0] AND   = 4'd8;
    localparam logic [3:0] MIN   = 4'd9;
    localparam logic [3:0] SLTU  = 4'd10;
    localparam logic [3:0] NOR   = 4'd11;

    typedef struct packed {
        logic [3:0]           opcode;
        logic [ALU_TAG_W-1:0] tag;
        logic [ALU_WIDTH-1:0] result;
        logic                 carry;
        logic                 zero;
        logic                 sign;
    } alu_entry_t;

    // The ALU drives carryFlag for every opcode, but it only carries
    // meaning for the adder/subtractor paths.
    function automatic logic carry_valid(input logic [3:0] opcode);
        return (opcode == ADD) || (opcode == SUB);
    endfunction

endpackage

// File: rtl/alu_result_fifo_mem.sv
// ---------------------------------------------------------------------------
// alu_result_fifo_mem
// DEPTH x alu_entry_t register array, one synchronous write port and one
// asynchronous read port. Contents are not reset.
// Ports:
//   clk      : rising-edge clock
//   we_i     : write enable
//   waddr_i  : write address
//   wdata_i  : entry to write
//   raddr_i  : read address
//   rdata_o  : entry at raddr_i (combinational)
// ---------------------------------------------------------------------------
module alu_result_fifo_mem
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  alu_entry_t    wdata_i,
    input  logic [AW-1:0] raddr_i,
    output alu_entry_t    rdata_o
);

    alu_entry_t mem_q [DEPTH];

    // Storage write; no reset so the array maps onto plain flops/LUTRAM.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/alu_result_queue.sv
// ---------------------------------------------------------------------------
// alu_result_queue
// Registered stage between the combinational ALU and the register file
// writeback. Queues ALU results (masked carry, zero, sign, opcode, tag) in a
// small FIFO and hands them out over valid/ready. Tracks sticky flags of
// retired results and counts retirements.
// Ports:
//   clk, rst                : clock, synchronous active-high reset
//   in_valid / in_ready     : ALU-side handshake (in_ready from occupancy only)
//   in_opcode/tag/result    : ALU result fields
//   in_carry/zero/sign      : ALU flags
//   out_valid / out_ready   : writeback-side handshake
//   out_opcode/tag/result   : head entry fields
//   out_carry/zero/sign     : head entry flags (carry already masked)
//   sticky_clr              : clear sticky flags
//   sticky_carry/zero/sign  : OR of retired flags since last clear
//   occupancy               : entries held, 0..DEPTH
//   retire_cnt              : number of popped entries (wraps)
// ---------------------------------------------------------------------------
module alu_result_queue
    import alu_pkg::*;
#(
    parameter int WIDTH = 128,
    parameter int TAG_W = 5,
    parameter int DEPTH = 4,
    parameter int CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [3:0]             in_opcode,
    input  logic [TAG_W-1:0]       in_tag,
    input  logic [WIDTH-1:0]       in_result,
    input  logic                   in_carry,
    input  logic                   in_zero,
    input  logic                   in_sign,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [3:0]             out_opcode,
    output logic [TAG_W-1:0]       out_tag,
    output logic [WIDTH-1:0]       out_result,
    output logic                   out_carry,
    output logic                   out_zero,
    output logic                   out_sign,
    input  logic                   sticky_clr,
    output logic                   sticky_carry,
    output logic                   sticky_zero,
    output logic                   sticky_sign,
    output logic [$clog2(DEPTH):0] occupancy,
    output logic [CNT_W-1:0]       retire_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int OW = AW + 1;

    logic [AW-1:0]    wrPtr_q, wrPtr_d;
    logic [AW-1:0]    rdPtr_q, rdPtr_d;
    logic [OW-1:0]    occ_q, occ_d;
    logic [2:0]       sticky_q, sticky_d;
    logic [CNT_W-1:0] retire_q, retire_d;
    alu_entry_t       hold_q, hold_d;

    alu_entry_t pushEntry;
    alu_entry_t memRd;
    alu_entry_t headEntry;
    logic       full;
    logic       push;
    logic       pop;

    assign full      = (occ_q == OW'(DEPTH));
    assign in_ready  = !full && !rst;
    assign out_valid = (occ_q != '0);
    assign push      = in_valid && in_ready;
    // Gating with rst keeps a pop in the reset cycle from touching counters.
    assign pop       = out_valid && out_ready && !rst;

    always_comb begin
        pushEntry.opcode = in_opcode;
        pushEntry.tag    = in_tag;
        pushEntry.result = in_result;
        pushEntry.carry  = in_carry && carry_valid(in_opcode);
        pushEntry.zero   = in_zero;
        pushEntry.sign   = in_sign;
    end

    alu_result_fifo_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .we_i    (push),
        .waddr_i (wrPtr_q),
        .wdata_i (pushEntry),
        .raddr_i (rdPtr_q),
        .rdata_o (memRd)
    );

    // When empty the outputs show the last popped entry (zero after reset)
    // so they never expose uninitialised storage.
    assign headEntry = out_valid ? memRd : hold_q;

    assign out_opcode   = headEntry.opcode;
    assign out_tag      = headEntry.tag;
    assign out_result   = headEntry.result;
    assign out_carry    = headEntry.carry;
    assign out_zero     = headEntry.zero;
    assign out_sign     = headEntry.sign;
    assign sticky_carry = sticky_q[2];
    assign sticky_zero  = sticky_q[1];
    assign sticky_sign  = sticky_q[0];
    assign occupancy    = occ_q;
    assign retire_cnt   = retire_q;

    // Next-state for pointers, occupancy, sticky flags and retire counter.
    always_comb begin
        wrPtr_d  = wrPtr_q + AW'(push);
        rdPtr_d  = rdPtr_q + AW'(pop);
        retire_d = retire_q + CNT_W'(pop);
        hold_d   = pop ? headEntry : hold_q;

        occ_d = occ_q;
        case ({push, pop})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase

        // A clear in the same cycle as a pop restarts from the popped flags.
        sticky_d = sticky_q;
        if (pop) begin
            sticky_d = (sticky_clr ? 3'b000 : sticky_q)
                     | {headEntry.carry, headEntry.zero, headEntry.sign};
        end else if (sticky_clr) begin
            sticky_d = 3'b000;
        end
    end

    // State registers with synchronous reset; queued entries are discarded
    // by zeroing occupancy and pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q  <= '0;
            rdPtr_q  <= '0;
            occ_q    <= '0;
            sticky_q <= '0;
            retire_q <= '0;
            hold_q   <= '0;
        end else begin
            wrPtr_q  <= wrPtr_d;
            rdPtr_q  <= rdPtr_d;
            occ_q    <= occ_d;
            sticky_q <= sticky_d;
            retire_q <= retire_d;
            hold_q   <= hold_d;
        end
    end

endmodule

// File: doc/alu_result_queue.md
Name: alu_result_queue

Overview:
- Registered stage directly downstream of the 128-bit combinational ALU.
- Captures each ALU result with its flags, opcode and destination tag into a small FIFO, then presents them to writeback over a valid/ready handshake.
- Cleans up the carry flag, keeps sticky flag status for the condition unit, and counts retired results.
- Breaks the long combinational path from the ALU into the register file.

Parameters:
WIDTH, 128, datapath width; must match ALU result width
TAG_W, 5, destination register tag width
DEPTH, 4, FIFO entries; power of two, >= 2
CNT_W, 32, retire counter width

Ports:
clk  input  1  single clock, rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  ALU result valid this cycle
in_ready  output  1  queue can accept
in_opcode  input  4  opcode driven to the ALU this cycle
in_tag  input  TAG_W  destination tag
in_result  input  WIDTH  ALU result
in_carry  input  1  ALU carryFlag
in_zero  input  1  ALU zeroFlag
in_sign  input  1  ALU signFlag
out_valid  output  1  head entry valid
out_ready  input  1  writeback accepts head
out_opcode  output  4  head opcode
out_tag  output  TAG_W  head tag
out_result  output  WIDTH  head result
out_carry  output  1  head carry (masked)
out_zero  output  1  head zero
out_sign  output  1  head sign
sticky_clr  input  1  clear sticky flags
sticky_carry  output  1  OR of retired carry since last clear
sticky_zero  output  1  OR of retired zero since last clear
sticky_sign  output  1  OR of retired sign since last clear
occupancy  output  $clog2(DEPTH)+1  entries held
retire_cnt  output  CNT_W  count of popped entries

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Push / pop:
  - push = in_valid && in_ready.
  - pop = out_valid && out_ready.
- Handshake signals:
  - in_ready = !full && !rst, decoded from registered occupancy only. It never depends on out_ready, so there is no combinational ready path.
  - out_valid = (occupancy != 0).
  - out_* show the head entry whenever out_valid=1. When out_valid=0 they hold their last value (don't-care, must not be X after reset).
- Latency: exactly 1 cycle from push to out_valid. There is no same-cycle bypass, even when empty.
- Carry masking:
  - At push, stored carry = in_carry only when in_opcode is ADD (1) or SUB (6); otherwise 0.
  - Zero, sign and result are stored unmodified.
- Simultaneous push and pop:
  - Not full: both take effect, occupancy unchanged, write/read pointers each advance.
  - Full: in_ready=0, so only the pop occurs.
  - Empty: only the push occurs; the new entry appears next cycle.
- Pointers: read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. occupancy is an explicit counter, 0..DEPTH.
- Sticky flags:
  - On pop, sticky_x <= sticky_x | out_x.
  - sticky_clr=1 alone: sticky_x <= 0.
  - sticky_clr and pop in the same cycle: sticky_x <= out_x of the popped entry (clear first, then accumulate).
- retire_cnt increments by 1 on each pop and wraps from 2^CNT_W-1 to 0.
- Reset values:
  - occupancy 0, pointers 0, out_valid 0, in_ready 0 during reset, 1 the cycle after.
  - sticky_* 0, retire_cnt 0, out_* 0. Storage contents need not be reset.
- Reset mid-operation: all queued entries are discarded. A push or pop presented in the reset cycle is ignored and does not affect the counters.
- Back-pressure: with out_ready held 0, head data stays stable until accepted.

Decomposition:
- Shared alu_pkg holds:
  - opcode localparams: XOR=0, ADD=1, SLT=2, SGE=3, PASSB=4, SRL=5, SUB=6, OR=7, AND=8, MIN=9, SLTU=10, NOR=11
  - typedef alu_entry_t {opcode, tag, result, carry, zero, sign}
  - function carry_valid(opcode)
- One sub-module, alu_result_fifo_mem: DEPTH x entry register array with one write port and one async read port.
- Pointer, occupancy, sticky and counter logic stays in the top module.

Test Plan:
- Reset, then single push (ADD, tag 3, result 128'h5, carry 1, zero 0, sign 0) with out_ready=1 -> out_valid=1 on the next cycle with the same fields; the cycle after, occupancy=0, retire_cnt=1, sticky_carry=1.
- Push XOR with in_carry=1 -> out_carry=0; push SUB with in_carry=1 -> out_carry=1.
- out_ready=0, push 4 entries (tags 0..3) -> in_ready=0 after the 4th and occupancy=4; a 5th in_valid is not accepted. Release out_ready -> tags pop in order 0,1,2,3.
- Occupancy 2, push and pop in the same cycle for 8 cycles -> occupancy stays 2, in-order data across pointer wrap, retire_cnt +8.
- sticky_clr asserted on the pop of an entry with zero=1 while sticky_sign=1 -> sticky_zero=1, sticky_sign=0, sticky_carry=0 (popped entry has carry=0, sign=0).
- rst pulsed with occupancy 3 and in_valid=1 -> next cycle occupancy=0, out_valid=0, retire_cnt=0, sticky_*=0.
